// File: rtl/tpic_pkg.sv
// Shared types and defaults for the TPIC relay-chain sequencer.
package tpic_pkg;
    localparam int unsigned FRAME_CNT_W        = 16;
    localparam int unsigned DEF_CLK_DIV        = 4;
    localparam int unsigned DEF_REFRESH_CYCLES = 5_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_BYPASS
    } state_e;

    // Counter width for a modulus of n, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tpic_bit_timer.sv
// Half-period phase counter for SCLK/RCK timing: first-cycle and terminal-count strobes.
module tpic_bit_timer
    import tpic_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    output logic first_c_o,
    output logic tc_c_o
);
    localparam int unsigned CW = cnt_w(CLK_DIV);

    logic [CW-1:0] cnt_q;

    assign first_c_o = en_i && (cnt_q == '0);
    assign tc_c_o    = en_i && (cnt_q == CW'(CLK_DIV - 1));

    // Wraps on terminal count so back-to-back phases restart cleanly.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (en_i && !tc_c_o) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end
endmodule

// File: rtl/tpic_chain_ctrl.sv
// TPIC relay-chain sequencer: snapshots relay memory, shifts it MSB first, latches with RCK and
// hands the chain to the diag bypass between frames. Define TPIC_READBACK_EN for the sin readback check.
module tpic_chain_ctrl
    import tpic_pkg::*;
#(
    parameter int unsigned WIDTH          = 300,
    parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
    parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       data,
    input  logic                   data_update,
    input  logic                   byps_req,
    output logic                   byps_gnt,
    output logic                   sclk,
    output logic                   sout,
    output logic                   rck,
    output logic                   g_n,
    input  logic                   sin,
    output logic                   busy,
    output logic                   fault,
    input  logic                   fault_clr,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam int unsigned IW = cnt_w(WIDTH);
    localparam int unsigned TW = cnt_w(REFRESH_CYCLES);

    state_e                 state_q;
    logic [WIDTH-1:0]       shadow_q;
    logic [IW-1:0]          idx_q;
    logic [TW-1:0]          timer_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   pending_q, byps_gnt_q, sclk_q, sout_q, rck_q, g_n_q, busy_q;
    logic                   timer_en_c, first_c, tc_c, refresh_hit_c, last_bit_c;

    assign timer_en_c    = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI) || (state_q == ST_LATCH);
    assign refresh_hit_c = (timer_q == TW'(REFRESH_CYCLES - 1));
    assign last_bit_c    = (idx_q == '0);

    tpic_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (timer_en_c),
        .first_c_o (first_c),
        .tc_c_o    (tc_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            pending_q   <= 1'b1;
            byps_gnt_q  <= 1'b0;
            sclk_q      <= 1'b0;
            sout_q      <= 1'b0;
            rck_q       <= 1'b0;
            g_n_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Saturates at the refresh point so a bypass parked there cannot wrap it.
                    if (!refresh_hit_c) timer_q <= timer_q + TW'(1);
                    if (byps_req) begin
                        state_q    <= ST_BYPASS;
                        byps_gnt_q <= 1'b1;
                        sclk_q     <= 1'b0;
                        sout_q     <= 1'b0;
                        rck_q      <= 1'b0;
                        if (refresh_hit_c) pending_q <= 1'b1;
                    end else if (pending_q || refresh_hit_c) begin
                        state_q   <= ST_LOAD;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shadow_q <= data;
                    idx_q    <= IW'(WIDTH - 1);
                    sout_q   <= data[WIDTH-1];
                    state_q  <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    if (tc_c) begin
                        sclk_q  <= 1'b1;
                        state_q <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tc_c) begin
                        sclk_q <= 1'b0;
                        if (last_bit_c) begin
                            sout_q  <= 1'b0;
                            rck_q   <= 1'b1;
                            state_q <= ST_LATCH;
                        end else begin
                            sout_q  <= shadow_q[idx_q - IW'(1)];
                            idx_q   <= idx_q - IW'(1);
                            state_q <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tc_c) begin
                        rck_q       <= 1'b0;
                        g_n_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                        timer_q     <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BYPASS: begin
                    if (!byps_req) begin
                        byps_gnt_q <= 1'b0;
                        pending_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // A late update always wins over the LOAD-entry clear: one more frame is guaranteed.
            if (data_update) pending_q <= 1'b1;
        end
    end

    assign byps_gnt  = byps_gnt_q;
    assign sclk      = sclk_q;
    assign sout      = sout_q;
    assign rck       = rck_q;
    assign g_n       = g_n_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

`ifdef TPIC_READBACK_EN
    logic [WIDTH-1:0] rb_q, prev_q, rb_next_c;
    logic             chain_valid_q, cmp_en_q, mismatch_c, fault_q;

    assign rb_next_c  = (state_q == ST_SHIFT_HI && first_c) ? {rb_q[WIDTH-2:0], sin} : rb_q;
    assign mismatch_c = cmp_en_q && (state_q == ST_SHIFT_HI) && tc_c && last_bit_c && (rb_next_c != prev_q);

    // chain_valid tracks whether the chain holds a complete frame we shifted ourselves.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rb_q          <= '0;
            prev_q        <= '0;
            chain_valid_q <= 1'b0;
            cmp_en_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            rb_q <= rb_next_c;
            if (state_q == ST_LOAD) begin
                prev_q   <= shadow_q;
                cmp_en_q <= chain_valid_q;
            end
            if (state_q == ST_LATCH && tc_c) chain_valid_q <= 1'b1;
            if (state_q == ST_BYPASS && !byps_req) chain_valid_q <= 1'b0;
            if (mismatch_c) begin
                fault_q <= 1'b1;
            end else if (fault_clr) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign fault = fault_q;
`else
    logic unused_rb;
    assign unused_rb = &{1'b0, sin, fault_clr, first_c};
    assign fault     = 1'b0;
`endif
endmodule

// File: tb/tb_tpic_chain_ctrl.sv
// Scoreboard bench for tpic_chain_ctrl: expected frames are queued at stimulus time and checked at RCK.
`timescale 1ns/1ps
module tb_tpic_chain_ctrl;
    localparam int unsigned W         = 16;
    localparam int unsigned CD        = 2;
    localparam int unsigned RC        = 100;
    localparam int unsigned LATCH_AT  = 1 + 2 * CD * W;
    localparam int unsigned FRAME_LEN = 1 + 2 * CD * W + CD;

    typedef struct {
        logic [W-1:0] word;
        int           gap;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n, data_update, byps_req, fault_clr;
    logic [W-1:0] data;
    logic         byps_gnt, sclk, sout, rck, g_n, busy, fault, sin;
    logic [15:0]  frame_cnt;

    logic [W-1:0] dl    = '0;
    logic         sin_q = 1'b0;
    logic         flip  = 1'b0;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    tpic_chain_ctrl #(.WIDTH(W), .CLK_DIV(CD), .REFRESH_CYCLES(RC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data        (data),
        .data_update (data_update),
        .byps_req    (byps_req),
        .byps_gnt    (byps_gnt),
        .sclk        (sclk),
        .sout        (sout),
        .rck         (rck),
        .g_n         (g_n),
        .sin         (sin),
        .busy        (busy),
        .fault       (fault),
        .fault_clr   (fault_clr),
        .frame_cnt   (frame_cnt)
    );

    // Chain model: W-bit delay, tail output updated on the falling shift clock.
    always @(posedge sclk) dl <= {dl[W-2:0], sout};
    always @(negedge sclk) sin_q <= dl[W-1];
    assign sin = sin_q ^ flip;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    endtask

    task automatic push_exp(input logic [W-1:0] w, input int g);
        exp_t e;
        e.word = w;
        e.gap  = g;
        sb.push_back(e);
    endtask

    // Frame monitor, sampled mid-cycle.
    int           cyc = 0, rise_cyc = 0, fall_cyc = 0, mon_frames = 0, nbits = 0, rck_hi = 0;
    logic [W-1:0] word = '0;
    logic         sclk_p = 1'b0, rck_p = 1'b0, busy_p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            mon_frames = 0;
            nbits      = 0;
            rck_hi     = 0;
            sclk_p     = 1'b0;
            rck_p      = 1'b0;
            busy_p     = 1'b0;
        end else begin
            if (sclk && !sclk_p) begin
                word = {word[W-2:0], sout};
                nbits++;
            end
            if (busy && !busy_p) begin
                rise_cyc = cyc;
                nbits    = 0;
                chk("load_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0 && sb[0].gap != 0) chk("idle_gap", cyc - fall_cyc, sb[0].gap);
            end
            if (rck && !rck_p) begin
                chk("latch_at", cyc - rise_cyc, LATCH_AT);
                chk("nbits", nbits, W);
                chk("rck_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("frame_data", word, e.word);
                end
                rck_hi = 0;
            end
            if (rck) rck_hi++;
            if (!rck && rck_p) chk("rck_width", rck_hi, CD);
            if (!busy && busy_p) begin
                fall_cyc = cyc;
                mon_frames++;
                chk("frame_len", cyc - rise_cyc, FRAME_LEN);
                chk("frame_cnt", frame_cnt, mon_frames);
                chk("g_n_enabled", g_n, 0);
            end
            if (byps_gnt) chk("bypass_quiet", {sclk, sout, rck}, 0);
            sclk_p = sclk;
            rck_p  = rck;
            busy_p = busy;
        end
    end

    task automatic wait_busy(input logic level, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (busy !== level && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, level);
    endtask

    task automatic wait_sclk_rises(input int n);
        int   rises, c;
        logic prev;
        rises = 0;
        c     = 0;
        prev  = sclk;
        while (rises < n && c < 1000) begin
            @(negedge clk);
            c++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        chk("sclk_rises", rises, n);
    endtask

    // Corrupt the k-th sin sample of the current frame (bit W-1-k of the previous frame).
    task automatic flip_sample(input int k);
        int   falls, c;
        logic prev;
        falls = 0;
        c     = 0;
        prev  = sclk;
        while (falls <= k && c < 1000) begin
            @(negedge clk);
            c++;
            if (!sclk && prev) begin
                falls++;
                if (falls == k) flip = 1'b1;
                else if (falls == k + 1) flip = 1'b0;
            end
            prev = sclk;
        end
        flip = 1'b0;
        chk("flip_done", falls, k + 1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        data        = 16'hA5C3;
        data_update = 1'b0;
        byps_req    = 1'b0;
        fault_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_sout", sout, 0);
        chk("rst_rck", rck, 0);
        chk("rst_g_n", g_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", byps_gnt, 0);
        chk("rst_fault", fault, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // First frame straight out of reset.
        push_exp(16'hA5C3, 0);
        reset_n = 1'b1;
        wait_busy(1, 10, "f1_start");
        wait_busy(0, 100, "f1_end");
        chk("f1_fault", fault, 0);

        // Two periodic refreshes.
        push_exp(16'hA5C3, RC);
        push_exp(16'hA5C3, RC);
        for (int i = 0; i < 2; i++) begin
            wait_busy(1, 200, "refresh_start");
            wait_busy(0, 100, "refresh_end");
        end

        // Update mid-frame: current frame unchanged, one more follows at once.
        push_exp(16'hA5C3, RC);
        wait_busy(1, 200, "upd_start");
        wait_sclk_rises(8);
        data        = 16'h0001;
        data_update = 1'b1;
        @(negedge clk);
        data_update = 1'b0;
        push_exp(16'h0001, 1);
        wait_busy(0, 100, "upd_end");
        wait_busy(1, 5, "upd_follow_start");
        wait_busy(0, 100, "upd_follow_end");

        // Bypass requested mid-frame.
        push_exp(16'h0001, RC);
        wait_busy(1, 200, "byp_frame_start");
        wait_sclk_rises(5);
        byps_req = 1'b1;
        wait_busy(0, 100, "byp_frame_end");
        chk("gnt_after_latch", byps_gnt, 0);
        @(negedge clk);
        chk("gnt_rise", byps_gnt, 1);
        chk("gnt_pins", {sclk, sout, rck}, 0);
        repeat (10) @(negedge clk);
        chk("byp_busy", busy, 0);
        chk("byp_frame_cnt", frame_cnt, 6);
        chk("byp_g_n", g_n, 0);
        push_exp(16'h0001, 0);
        byps_req = 1'b0;
        @(negedge clk);
        chk("gnt_drop", byps_gnt, 0);
        @(negedge clk);
        chk("resync_load", busy, 1);
        wait_busy(0, 100, "resync_end");

        // Reset during SHIFT_HI aborts the frame.
        push_exp(16'h0001, RC);
        wait_busy(1, 200, "abort_start");
        wait_sclk_rises(3);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_sclk", sclk, 0);
        chk("abort_sout", sout, 0);
        chk("abort_rck", rck, 0);
        chk("abort_g_n", g_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_frame_cnt", frame_cnt, 0);
        repeat (3) @(negedge clk);
        chk("abort_rck_hold", rck, 0);
        push_exp(16'h0001, 0);
        reset_n = 1'b1;
        wait_busy(1, 10, "post_rst_start");
        wait_busy(0, 100, "post_rst_end");

`ifdef TPIC_READBACK_EN
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        data = 16'hA5C3;
        push_exp(16'hA5C3, 0);
        reset_n = 1'b1;
        wait_busy(1, 10, "rb_f1_start");
        wait_busy(0, 100, "rb_f1_end");
        chk("rb_f1_fault", fault, 0);
        push_exp(16'hA5C3, RC);
        wait_busy(1, 200, "rb_f2_start");
        wait_busy(0, 100, "rb_f2_end");
        chk("rb_f2_fault", fault, 0);
        push_exp(16'hA5C3, RC);
        wait_busy(1, 200, "rb_f3_start");
        flip_sample(W - 1 - 3);
        while (!rck && busy) @(negedge clk);
        chk("rb_f3_fault_at_latch", fault, 1);
        wait_busy(0, 100, "rb_f3_end");
        chk("rb_fault_sticky", fault, 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        chk("rb_fault_clr", fault, 0);
        byps_req = 1'b1;
        repeat (2) @(negedge clk);
        push_exp(16'hA5C3, 0);
        byps_req = 1'b0;
        wait_busy(1, 10, "rb_resync_start");
        flip_sample(W - 1 - 3);
        wait_busy(0, 100, "rb_resync_end");
        chk("rb_skip_after_bypass", fault, 0);
        push_exp(16'hA5C3, RC);
        wait_busy(1, 200, "rb_clean_start");
        wait_busy(0, 100, "rb_clean_end");
        chk("rb_clean_fault", fault, 0);
`else
        push_exp(16'h0001, RC);
        wait_busy(1, 200, "tied_start");
        flip_sample(W - 1 - 3);
        wait_busy(0, 100, "tied_end");
        chk("fault_tied", fault, 0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tpic_chain_ctrl.md
Name: tpic_chain_ctrl

Overview:
- Sequencer for the TPIC relay-driver shift-register chain.
- Snapshots the flat relay memory and serialises it into the chain, MSB first, then pulses RCK. Runs on memory update and on a periodic refresh timer.
- Arbitrates chain ownership between itself and the microcontroller diagnostic bypass, granting the bypass only on frame boundaries.
- Sits between the SLU memory block and the top-level TPIC/diag pin muxing; it replaces the free-running memory-to-TPIC serialiser.

Parameters:
- WIDTH, 300, chain length in bits; equals flat relay memory width.
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1).
- REFRESH_CYCLES, 5_000_000, idle clk cycles between periodic refresh frames (100 ms at 50 MHz).

Ports:
- clk  in  1  50 MHz system clock.
- reset_n  in  1  synchronous, active-low reset.
- data  in  WIDTH  relay memory image.
- data_update  in  1  one-clk pulse: memory changed (already synchronised to clk).
- byps_req  in  1  diag bypass request (already synchronised).
- byps_gnt  out  1  high while the diag SPI owns the chain.
- sclk  out  1  TPIC shift clock.
- sout  out  1  TPIC serial data in.
- rck  out  1  TPIC register latch.
- g_n  out  1  TPIC output enable, active low.
- sin  in  1  TPIC serial out (chain tail).
- busy  out  1  high from LOAD through LATCH.
- fault  out  1  sticky readback mismatch.
- fault_clr  in  1  one-clk pulse: clears fault.
- frame_cnt  out  16  completed frames; wraps at 0xFFFF→0.

Behaviour:
- Reset values while reset_n=0 at a clk edge: sclk=0, sout=0, rck=0, g_n=1, busy=0, byps_gnt=0, fault=0, frame_cnt=0, pending=1, state=IDLE, timer=0.
  - Reset mid-frame aborts the frame; no partial RCK is issued.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, BYPASS.
- pending:
  - Set by data_update in any state, or by timer reaching REFRESH_CYCLES-1 in IDLE.
  - Cleared on entry to LOAD.
  - A data_update arriving during a frame guarantees exactly one further frame afterwards.
- IDLE:
  - If byps_req=1, go to BYPASS; bypass has priority over pending.
  - Else if pending, go to LOAD.
  - Timer increments only in IDLE and resets to 0 on LATCH exit.
- LOAD (1 cycle): shadow ← data; bit index ← WIDTH-1; sout ← shadow MSB; busy=1.
- SHIFT_LO: sclk=0 for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: sclk=1 for CLK_DIV cycles.
  - sin is sampled on the first cycle of SHIFT_HI.
  - On exit, sout advances to the next bit.
  - If index=0, go to LATCH; else decrement index and go to SHIFT_LO.
- LATCH:
  - sclk=0, rck=1 for CLK_DIV cycles.
  - Then rck=0, g_n=0 (held low thereafter until reset), frame_cnt++, busy=0, go to IDLE.
- Frame length is exactly 1 + 2·CLK_DIV·WIDTH + CLK_DIV clk cycles, from LOAD through the last LATCH cycle.
- byps_req asserted mid-frame: the frame completes unchanged; BYPASS is entered from IDLE on the next cycle.
- BYPASS:
  - byps_gnt=1; sclk, sout, rck held 0; g_n keeps its value.
  - On byps_req=0: byps_gnt=0, pending set (forced resync), readback marked invalid, go to IDLE.
- fault_clr and a mismatch on the same cycle: set wins.

Optional Feature:
- Macro: TPIC_READBACK_EN.
- Defined:
  - Bits sampled on sin form the previous frame's contents. They are compared bitwise against the previous shadow.
  - Any mismatch sets fault at LATCH entry.
  - Comparison is skipped when no valid previous frame exists: after reset or after BYPASS.
- Undefined: sin is ignored, fault is tied 0, fault_clr is unused, and no second shadow register is synthesised.

Decomposition:
- Package tpic_pkg: state enumeration, FRAME_CNT_W=16, default CLK_DIV and REFRESH_CYCLES constants.
- One sub-module, tpic_bit_timer: CLK_DIV phase counter producing the half-period terminal-count pulse. Shared by the SHIFT and LATCH states.

Test Plan:
All scenarios use WIDTH=16, CLK_DIV=2, REFRESH_CYCLES=100 unless stated.
- Release reset with data=16'hA5C3 → one frame starts (pending=1); sout bit sequence 1010_0101_1100_0011 sampled at sclk rises; rck high 2 cycles at cycle 66 after LOAD; g_n falls after LATCH; frame_cnt=1.
- Idle with no updates → next frame LOAD occurs exactly 100 cycles after LATCH exit; frame_cnt increments each period.
- data_update pulse at bit index 8 of a frame, data changed to 16'h0001 → current frame still shifts 16'hA5C3; a second frame with 16'h0001 follows immediately after IDLE.
- byps_req raised mid-frame → byps_gnt rises 1 cycle after LATCH ends with sclk/sout/rck=0; drop byps_req → byps_gnt=0 next cycle, resync frame starts.
- TPIC_READBACK_EN, sin looped from a 16-bit delay model, bit 3 forced wrong on frame 3 → fault=1 at frame 3 LATCH, not on frames 1–2 or the first frame after bypass; fault_clr pulse → fault=0.
- Reset asserted during SHIFT_HI → next clk all outputs at reset values, no rck pulse; frame_cnt=0.
